// File: rtl/alu_issue_queue_pkg.sv
// Shared widths and ALU opcode encodings for the ALU issue queue slice.
// The macros are defined here so every later file in the compile sees them.
`ifndef ALU_ISSUE_QUEUE_DEFINES
`define ALU_ISSUE_QUEUE_DEFINES
`define DATA_WIDTH_ALU_OP 4
`define PC_WIDTH 32
`define WORD_WIDTH 32
`define PREG_W_DEFAULT 6
`define ROB_W_DEFAULT 5
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_AND  4'd2
`define ALU_OP_OR   4'd3
`define ALU_OP_XOR  4'd4
`define ALU_OP_SLL  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_SLT  4'd8
`define ALU_OP_SLTU 4'd9
`define ALU_OP_ADDI 4'd10
`endif

package alu_issue_queue_pkg;
  localparam int OP_W   = `DATA_WIDTH_ALU_OP;
  localparam int PC_W   = `PC_WIDTH;
  localparam int WORD_W = `WORD_WIDTH;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = `ALU_OP_ADD,
    ALU_SUB  = `ALU_OP_SUB,
    ALU_AND  = `ALU_OP_AND,
    ALU_OR   = `ALU_OP_OR,
    ALU_XOR  = `ALU_OP_XOR,
    ALU_SLL  = `ALU_OP_SLL,
    ALU_SRL  = `ALU_OP_SRL,
    ALU_SRA  = `ALU_OP_SRA,
    ALU_SLT  = `ALU_OP_SLT,
    ALU_SLTU = `ALU_OP_SLTU,
    ALU_ADDI = `ALU_OP_ADDI
  } alu_op_e;
endpackage

// File: rtl/alu_issue_queue_wakeup_match.sv
// Compares one source tag against every writeback port; the lowest-numbered
// matching port supplies the captured value.
module iq_wakeup_match
  import alu_issue_queue_pkg::*;
#(
  parameter int PREG_W   = `PREG_W_DEFAULT,
  parameter int WB_PORTS = 2
) (
  input  logic [PREG_W-1:0]          tag,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_tag,
  input  logic [WB_PORTS*WORD_W-1:0] wb_value,
  output logic                       hit,
  output logic [WORD_W-1:0]          value
);
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*PREG_W +: PREG_W] == tag)) begin
        hit   = 1'b1;
        value = wb_value[p*WORD_W +: WORD_W];
      end
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing reservation station in front of the ALU: captures operands from
// the writeback bus and issues the oldest fully-ready entry each cycle.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PREG_W   = `PREG_W_DEFAULT,
  parameter int ROB_W    = `ROB_W_DEFAULT,
  parameter int WB_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [`DATA_WIDTH_ALU_OP-1:0]    disp_op,
  input  logic [`PC_WIDTH-1:0]             disp_pc,
  input  logic [`WORD_WIDTH-1:0]           disp_imm,
  input  logic [PREG_W-1:0]                disp_rs1_tag,
  input  logic [PREG_W-1:0]                disp_rs2_tag,
  input  logic                             disp_rs1_rdy,
  input  logic                             disp_rs2_rdy,
  input  logic [`WORD_WIDTH-1:0]           disp_rs1_value,
  input  logic [`WORD_WIDTH-1:0]           disp_rs2_value,
  input  logic [PREG_W-1:0]                disp_prd,
  input  logic [ROB_W-1:0]                 disp_rob_id,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]       wb_tag,
  input  logic [WB_PORTS*`WORD_WIDTH-1:0]  wb_value,
  output logic                             alu_issue_en,
  output logic [`DATA_WIDTH_ALU_OP-1:0]    alu_issue_queue_op,
  output logic [`PC_WIDTH-1:0]             alu_issue_queue_pc,
  output logic [`WORD_WIDTH-1:0]           alu_issue_queue_imm,
  output logic [`WORD_WIDTH-1:0]           alu_issue_queue_rs1_value,
  output logic [`WORD_WIDTH-1:0]           alu_issue_queue_rs2_value,
  output logic [PREG_W-1:0]                alu_issue_prd,
  output logic [ROB_W-1:0]                 alu_issue_rob_id,
  output logic [$clog2(DEPTH):0]           count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic              e_valid [DEPTH];
  logic [OP_W-1:0]   e_op    [DEPTH];
  logic [PC_W-1:0]   e_pc    [DEPTH];
  logic [WORD_W-1:0] e_imm   [DEPTH];
  logic [PREG_W-1:0] e_t1    [DEPTH];
  logic [PREG_W-1:0] e_t2    [DEPTH];
  logic              e_r1    [DEPTH];
  logic              e_r2    [DEPTH];
  logic [WORD_W-1:0] e_v1    [DEPTH];
  logic [WORD_W-1:0] e_v2    [DEPTH];
  logic [PREG_W-1:0] e_prd   [DEPTH];
  logic [ROB_W-1:0]  e_rob   [DEPTH];

  logic              w_hit1 [DEPTH];
  logic              w_hit2 [DEPTH];
  logic [WORD_W-1:0] w_hv1  [DEPTH];
  logic [WORD_W-1:0] w_hv2  [DEPTH];
  logic              w_r1   [DEPTH];
  logic              w_r2   [DEPTH];
  logic [WORD_W-1:0] w_v1   [DEPTH];
  logic [WORD_W-1:0] w_v2   [DEPTH];

  logic              n_valid [DEPTH];
  logic [OP_W-1:0]   n_op    [DEPTH];
  logic [PC_W-1:0]   n_pc    [DEPTH];
  logic [WORD_W-1:0] n_imm   [DEPTH];
  logic [PREG_W-1:0] n_t1    [DEPTH];
  logic [PREG_W-1:0] n_t2    [DEPTH];
  logic              n_r1    [DEPTH];
  logic              n_r2    [DEPTH];
  logic [WORD_W-1:0] n_v1    [DEPTH];
  logic [WORD_W-1:0] n_v2    [DEPTH];
  logic [PREG_W-1:0] n_prd   [DEPTH];
  logic [ROB_W-1:0]  n_rob   [DEPTH];
  logic [CW-1:0]     n_count;

  logic              d_hit1, d_hit2, d_r1, d_r2, acc, sel_found;
  logic [WORD_W-1:0] d_hv1, d_hv2, d_v1, d_v2;
  logic [IW-1:0]     sel_idx;

  assign disp_ready = (count != CW'(DEPTH));
  assign acc        = disp_valid && disp_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_wake
    iq_wakeup_match #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_m1 (
      .tag(e_t1[g]), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .hit(w_hit1[g]), .value(w_hv1[g]));
    iq_wakeup_match #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_m2 (
      .tag(e_t2[g]), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .hit(w_hit2[g]), .value(w_hv2[g]));
    assign w_r1[g] = e_r1[g] | w_hit1[g];
    assign w_r2[g] = e_r2[g] | w_hit2[g];
    assign w_v1[g] = e_r1[g] ? e_v1[g] : w_hv1[g];
    assign w_v2[g] = e_r2[g] ? e_v2[g] : w_hv2[g];
  end

  iq_wakeup_match #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_disp_m1 (
    .tag(disp_rs1_tag), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .hit(d_hit1), .value(d_hv1));
  iq_wakeup_match #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_disp_m2 (
    .tag(disp_rs2_tag), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .hit(d_hit2), .value(d_hv2));
  assign d_r1 = disp_rs1_rdy | d_hit1;
  assign d_r2 = disp_rs2_rdy | d_hit2;
  assign d_v1 = disp_rs1_rdy ? disp_rs1_value : d_hv1;
  assign d_v2 = disp_rs2_rdy ? disp_rs2_value : d_hv2;

  // Oldest-first select from registered readiness only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (e_valid[i] && e_r1[i] && e_r2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Collapse above the issued slot, then append the dispatch at the new tail.
  always_comb begin
    int            cnt_after;
    int            src;
    logic [IW-1:0] src_i;
    cnt_after = int'(count) - (sel_found ? 1 : 0);
    src       = 0;
    src_i     = '0;
    n_count   = CW'(cnt_after + (acc ? 1 : 0));
    for (int i = 0; i < DEPTH; i++) begin
      src = (sel_found && (i >= int'(sel_idx))) ? i + 1 : i;
      if (src >= DEPTH) src = i;
      src_i      = IW'(src);
      n_valid[i] = (i < cnt_after + (acc ? 1 : 0));
      n_op[i]    = e_op[src_i];
      n_pc[i]    = e_pc[src_i];
      n_imm[i]   = e_imm[src_i];
      n_t1[i]    = e_t1[src_i];
      n_t2[i]    = e_t2[src_i];
      n_r1[i]    = w_r1[src_i];
      n_r2[i]    = w_r2[src_i];
      n_v1[i]    = w_v1[src_i];
      n_v2[i]    = w_v2[src_i];
      n_prd[i]   = e_prd[src_i];
      n_rob[i]   = e_rob[src_i];
      if (acc && (i == cnt_after)) begin
        n_op[i]  = disp_op;
        n_pc[i]  = disp_pc;
        n_imm[i] = disp_imm;
        n_t1[i]  = disp_rs1_tag;
        n_t2[i]  = disp_rs2_tag;
        n_r1[i]  = d_r1;
        n_r2[i]  = d_r2;
        n_v1[i]  = d_v1;
        n_v2[i]  = d_v2;
        n_prd[i] = disp_prd;
        n_rob[i] = disp_rob_id;
      end
    end
  end

  // Control state and registered issue interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count                     <= '0;
      e_valid                   <= '{default: 1'b0};
      alu_issue_en              <= 1'b0;
      alu_issue_queue_op        <= '0;
      alu_issue_queue_pc        <= '0;
      alu_issue_queue_imm       <= '0;
      alu_issue_queue_rs1_value <= '0;
      alu_issue_queue_rs2_value <= '0;
      alu_issue_prd             <= '0;
      alu_issue_rob_id          <= '0;
    end else if (flush) begin
      count        <= '0;
      e_valid      <= '{default: 1'b0};
      alu_issue_en <= 1'b0;
    end else begin
      count        <= n_count;
      e_valid      <= n_valid;
      alu_issue_en <= sel_found;
      if (sel_found) begin
        alu_issue_queue_op        <= e_op[sel_idx];
        alu_issue_queue_pc        <= e_pc[sel_idx];
        alu_issue_queue_imm       <= e_imm[sel_idx];
        alu_issue_queue_rs1_value <= e_v1[sel_idx];
        alu_issue_queue_rs2_value <= e_v2[sel_idx];
        alu_issue_prd             <= e_prd[sel_idx];
        alu_issue_rob_id          <= e_rob[sel_idx];
      end
    end
  end

  // Payload storage; meaningful only where e_valid is set.
  always_ff @(posedge clk) begin
    e_op  <= n_op;
    e_pc  <= n_pc;
    e_imm <= n_imm;
    e_t1  <= n_t1;
    e_t2  <= n_t2;
    e_r1  <= n_r1;
    e_r2  <= n_r2;
    e_v1  <= n_v1;
    e_v2  <= n_v2;
    e_prd <= n_prd;
    e_rob <= n_rob;
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue against a queue-based reference model,
// with directed scenarios whose outcomes are also pinned by literal values.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_pc, disp_imm, disp_rs1_value, disp_rs2_value;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_prd;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [4:0]  disp_rob_id;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [63:0] wb_value;
  logic        alu_issue_en;
  logic [3:0]  alu_issue_queue_op;
  logic [31:0] alu_issue_queue_pc, alu_issue_queue_imm;
  logic [31:0] alu_issue_queue_rs1_value, alu_issue_queue_rs2_value;
  logic [5:0]  alu_issue_prd;
  logic [4:0]  alu_issue_rob_id;
  logic [3:0]  count;

  alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(6), .ROB_W(5), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
    .disp_prd(disp_prd), .disp_rob_id(disp_rob_id),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .alu_issue_en(alu_issue_en), .alu_issue_queue_op(alu_issue_queue_op),
    .alu_issue_queue_pc(alu_issue_queue_pc), .alu_issue_queue_imm(alu_issue_queue_imm),
    .alu_issue_queue_rs1_value(alu_issue_queue_rs1_value),
    .alu_issue_queue_rs2_value(alu_issue_queue_rs2_value),
    .alu_issue_prd(alu_issue_prd), .alu_issue_rob_id(alu_issue_rob_id),
    .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc, imm, v1, v2;
    logic [5:0]  t1, t2, prd;
    bit          r1, r2;
    logic [4:0]  rob;
  } ent_t;

  ent_t        q[$];
  bit          m_en;
  logic [3:0]  m_op;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [5:0]  m_prd;
  logic [4:0]  m_rob;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A waiting source picks up the first matching broadcast port, if any.
  function automatic void wake(input logic [5:0] tag, input bit r_in, input logic [31:0] v_in,
                               output bit r, output logic [31:0] v);
    r = r_in;
    v = v_in;
    if (!r_in)
      for (int p = 0; p < 2; p++)
        if (!r && wb_valid[p] && wb_tag[p*6 +: 6] == tag) begin
          r = 1'b1;
          v = wb_value[p*32 +: 32];
        end
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_op = '0; m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0; m_prd = '0; m_rob = '0;
  endtask

  task automatic model_step();
    int   sel;
    bit   acc, r;
    logic [31:0] v;
    ent_t ne;
    if (flush) begin
      q.delete();
      m_en = 0;
      return;
    end
    acc = disp_valid && (q.size() != DEPTH);
    sel = -1;
    for (int i = 0; i < q.size(); i++)
      if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
    for (int i = 0; i < q.size(); i++) begin
      wake(q[i].t1, q[i].r1, q[i].v1, r, v); q[i].r1 = r; q[i].v1 = v;
      wake(q[i].t2, q[i].r2, q[i].v2, r, v); q[i].r2 = r; q[i].v2 = v;
    end
    if (sel >= 0) begin
      m_en = 1; m_op = q[sel].op; m_pc = q[sel].pc; m_imm = q[sel].imm;
      m_v1 = q[sel].v1; m_v2 = q[sel].v2; m_prd = q[sel].prd; m_rob = q[sel].rob;
      q.delete(sel);
    end else m_en = 0;
    if (acc) begin
      ne.op = disp_op; ne.pc = disp_pc; ne.imm = disp_imm; ne.prd = disp_prd; ne.rob = disp_rob_id;
      ne.t1 = disp_rs1_tag; ne.t2 = disp_rs2_tag;
      wake(disp_rs1_tag, disp_rs1_rdy, disp_rs1_value, r, v); ne.r1 = r; ne.v1 = v;
      wake(disp_rs2_tag, disp_rs2_rdy, disp_rs2_value, r, v); ne.r2 = r; ne.v2 = v;
      q.push_back(ne);
    end
  endtask

  task automatic check_all();
    chk("count", count, q.size());
    chk("disp_ready", disp_ready, q.size() != DEPTH);
    chk("issue_en", alu_issue_en, m_en);
    chk("op", alu_issue_queue_op, m_op);
    chk("pc", alu_issue_queue_pc, m_pc);
    chk("imm", alu_issue_queue_imm, m_imm);
    chk("rs1_value", alu_issue_queue_rs1_value, m_v1);
    chk("rs2_value", alu_issue_queue_rs2_value, m_v2);
    chk("prd", alu_issue_prd, m_prd);
    chk("rob_id", alu_issue_rob_id, m_rob);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; wb_valid = '0; wb_tag = '0; wb_value = '0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] imm,
                          input logic [5:0] t1, input bit r1, input logic [31:0] v1,
                          input logic [5:0] t2, input bit r2, input logic [31:0] v2,
                          input logic [5:0] prd, input logic [4:0] rob);
    disp_valid = 1; disp_op = op; disp_pc = 32'h1000 + {27'd0, rob} * 4; disp_imm = imm;
    disp_rs1_tag = t1; disp_rs1_rdy = r1; disp_rs1_value = v1;
    disp_rs2_tag = t2; disp_rs2_rdy = r2; disp_rs2_value = v2;
    disp_prd = prd; disp_rob_id = rob;
  endtask

  task automatic set_wb(input int p, input logic [5:0] tag, input logic [31:0] val);
    wb_valid[p] = 1'b1;
    wb_tag[p*6 +: 6] = tag;
    wb_value[p*32 +: 32] = val;
  endtask

  task automatic rand_cycle();
    bit r;
    idle();
    flush = ($urandom_range(0, 49) == 0);
    if ($urandom_range(0, 2) != 0) begin
      r = $urandom_range(0, 1);
      set_disp(4'($urandom_range(0, 10)), $urandom, 6'($urandom_range(1, 15)), r,
               r ? $urandom : 32'd0, 6'($urandom_range(1, 15)), $urandom_range(0, 1), $urandom,
               6'($urandom_range(1, 63)), 5'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        disp_rs1_tag = '0; disp_rs1_rdy = 1; disp_rs1_value = '0;
      end
    end
    for (int p = 0; p < 2; p++)
      if ($urandom_range(0, 1) == 1) set_wb(p, 6'($urandom_range(1, 15)), $urandom);
    cycle();
  endtask

  initial begin
    rst = 1;
    idle();
    disp_op = '0; disp_pc = '0; disp_imm = '0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    disp_rs1_rdy = 0; disp_rs2_rdy = 0; disp_rs1_value = '0; disp_rs2_value = '0;
    disp_prd = '0; disp_rob_id = '0;
    model_reset();
    #2;
    chk("reset_count", count, 0);
    chk("reset_en", alu_issue_en, 0);
    chk("reset_rs1", alu_issue_queue_rs1_value, 0);
    chk("reset_prd", alu_issue_prd, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", disp_ready, 1);

    // ADDI with ready operands issues one cycle after dispatch.
    set_disp(ALU_ADDI, 32'd3, 6'd4, 1, 32'd5, 6'd0, 1, 32'd0, 6'd7, 5'd1);
    cycle();
    idle();
    chk("addi_not_yet", alu_issue_en, 0);
    cycle();
    chk("addi_en", alu_issue_en, 1);
    chk("addi_rs1", alu_issue_queue_rs1_value, 32'd5);
    chk("addi_imm", alu_issue_queue_imm, 32'd3);
    chk("addi_prd", alu_issue_prd, 6'd7);
    chk("addi_count", count, 0);

    // rs2 waits for a broadcast two cycles after dispatch.
    set_disp(ALU_ADD, 32'd0, 6'd0, 1, 32'd0, 6'd12, 0, 32'd0, 6'd8, 5'd2);
    cycle();
    idle(); cycle();
    set_wb(0, 6'd12, 32'h10); cycle();
    idle();
    chk("wb_not_yet", alu_issue_en, 0);
    cycle();
    chk("wb_en", alu_issue_en, 1);
    chk("wb_rs2", alu_issue_queue_rs2_value, 32'h10);

    // Fill with eight waiting entries, then offer a ninth.
    for (int i = 0; i < 8; i++) begin
      set_disp(ALU_SUB, 32'd0, 6'(20 + i), 0, 32'd0, 6'd0, 1, 32'd0, 6'(40 + i), 5'(i));
      cycle();
    end
    set_disp(ALU_SUB, 32'd0, 6'd1, 1, 32'd0, 6'd0, 1, 32'd0, 6'd50, 5'd8);
    chk("full_ready", disp_ready, 0);
    cycle();
    chk("full_count", count, 8);
    idle(); set_wb(0, 6'd23, 32'h33); cycle();
    idle(); cycle();
    chk("mid_en", alu_issue_en, 1);
    chk("mid_rob", alu_issue_rob_id, 5'd3);
    chk("mid_rs1", alu_issue_queue_rs1_value, 32'h33);
    chk("mid_count", count, 7);
    chk("mid_ready", disp_ready, 1);

    // Two wakeups in one cycle issue in age order.
    set_wb(0, 6'd22, 32'h22); set_wb(1, 6'd26, 32'h26); cycle();
    idle(); cycle();
    chk("age_first", alu_issue_rob_id, 5'd2);
    cycle();
    chk("age_second_en", alu_issue_en, 1);
    chk("age_second", alu_issue_rob_id, 5'd6);
    flush = 1; cycle(); idle();

    // Dispatch-cycle wakeup.
    set_disp(ALU_OR, 32'd0, 6'd9, 0, 32'd0, 6'd0, 1, 32'd0, 6'd11, 5'd9);
    set_wb(1, 6'd9, 32'hABCD); cycle();
    idle(); cycle();
    chk("bypass_en", alu_issue_en, 1);
    chk("bypass_rs1", alu_issue_queue_rs1_value, 32'hABCD);

    // Flush with four entries, a ready one and a dispatch in flight.
    for (int i = 0; i < 3; i++) begin
      set_disp(ALU_XOR, 32'd0, 6'(30 + i), 0, 32'd0, 6'd0, 1, 32'd0, 6'd12, 5'(10 + i));
      cycle();
    end
    set_disp(ALU_AND, 32'd0, 6'd0, 1, 32'd0, 6'd0, 1, 32'd0, 6'd13, 5'd13); cycle();
    idle();
    chk("pre_flush_count", count, 4);
    flush = 1;
    set_disp(ALU_AND, 32'd0, 6'd0, 1, 32'd0, 6'd0, 1, 32'd0, 6'd14, 5'd14);
    cycle();
    chk("flush_count", count, 0);
    chk("flush_en", alu_issue_en, 0);
    idle();

    for (int n = 0; n < 2000; n++) rand_cycle();

    // Asynchronous reset in the middle of traffic.
    idle();
    set_disp(ALU_ADD, 32'd1, 6'd0, 1, 32'd7, 6'd0, 1, 32'd8, 6'd3, 5'd3);
    #2 rst = 1;
    #1;
    chk("async_count", count, 0);
    chk("async_en", alu_issue_en, 0);
    chk("async_rs2", alu_issue_queue_rs2_value, 0);
    chk("async_rob", alu_issue_rob_id, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle();
    for (int n = 0; n < 300; n++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
